// File: rtl/dbg_cmd_bridge.sv
// -----------------------------------------------------------------------------
// dbg_cmd_bridge
//
// Debug-bus master that buffers host debug commands in a small FIFO and issues
// them one at a time to one of N_TGT debug-bus targets (VexRiscv debug ports).
// Read data is captured one cycle after the command fires. Reads, and any
// command that times out or names a nonexistent target, produce a response on
// a valid/ready channel back to the host. Responses come back in command order.
//
// Ports
//   clk, reset                  single clock; asynchronous active-high reset
//   host_cmd_*                  host command channel (valid/ready), pushed into the FIFO
//   host_rsp_*                  host response channel (valid/ready), data=0 on error
//   dbg_cmd_valid[N_TGT]        one-hot command valid, one bit per target
//   dbg_cmd_ready[N_TGT]        per-target ready
//   dbg_cmd_payload_*           command payload, shared by all targets
//   dbg_rsp_data                target i read data at [i*DATA_W +: DATA_W]
//   dbg_resetOut / tgt_reset_req  per-target reset request, registered once
// -----------------------------------------------------------------------------
module dbg_cmd_bridge #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 32,
   parameter int N_TGT      = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 255,
   parameter int TGT_W      = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    host_cmd_valid,
   output logic                    host_cmd_ready,
   input  logic                    host_cmd_wr,
   input  logic [TGT_W-1:0]        host_cmd_tgt,
   input  logic [ADDR_W-1:0]       host_cmd_addr,
   input  logic [DATA_W-1:0]       host_cmd_data,
   output logic                    host_rsp_valid,
   input  logic                    host_rsp_ready,
   output logic [DATA_W-1:0]       host_rsp_data,
   output logic                    host_rsp_err,
   output logic [N_TGT-1:0]        dbg_cmd_valid,
   input  logic [N_TGT-1:0]        dbg_cmd_ready,
   output logic                    dbg_cmd_payload_wr,
   output logic [ADDR_W-1:0]       dbg_cmd_payload_address,
   output logic [DATA_W-1:0]       dbg_cmd_payload_data,
   input  logic [N_TGT*DATA_W-1:0] dbg_rsp_data,
   input  logic [N_TGT-1:0]        dbg_resetOut,
   output logic [N_TGT-1:0]        tgt_reset_req
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [TGT_W:0]   N_TGT_EXT = (TGT_W + 1)'(N_TGT);

   typedef struct packed {
      logic              wr;
      logic [TGT_W-1:0]  tgt;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

   // ---------------------------------------------------------------- FIFO
   cmd_t             mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [PTR_W:0]   count;
   logic             fifo_push, fifo_pop;
   cmd_t             head;
   state_t           state;

   assign host_cmd_ready = (count != FIFO_FULL);
   assign fifo_push      = host_cmd_valid && host_cmd_ready;
   assign fifo_pop       = (state == S_IDLE) && (count != '0);
   assign head           = mem[rd_ptr];

   // NOTE: storage array carries no reset; occupancy is tracked by count, so
   // stale entries are never observed and the array can map to plain RAM.
   always_ff @(posedge clk) begin
      if (fifo_push) mem[wr_ptr] <= '{wr: host_cmd_wr, tgt: host_cmd_tgt,
                                      addr: host_cmd_addr, data: host_cmd_data};
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // Pointers are PTR_W wide, so they wrap modulo FIFO_DEPTH by themselves.
         if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({fifo_push, fifo_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- issue path
   logic              issue_wr;
   logic [TGT_W-1:0]  issue_tgt;
   logic [ADDR_W-1:0] issue_addr;
   logic [DATA_W-1:0] issue_data;
   logic [CNT_W-1:0]  to_cnt;
   logic [DATA_W-1:0] rsp_sel;
   logic              head_bad;
   logic              fire;

   assign dbg_cmd_payload_wr      = issue_wr;
   assign dbg_cmd_payload_address = issue_addr;
   assign dbg_cmd_payload_data    = issue_data;

   assign head_bad = {1'b0, head.tgt} >= N_TGT_EXT;
   // Valid is one-hot on the selected target, so masking ready with it picks
   // exactly that target's ready.
   assign fire     = |(dbg_cmd_ready & dbg_cmd_valid);

   // NOTE: every combinational output gets a default before the loop so no
   // path leaves it unassigned (which would infer a latch).
   always_comb begin
      rsp_sel = '0;
      for (int i = 0; i < N_TGT; i++) begin
         if (issue_tgt == TGT_W'(i)) rsp_sel = dbg_rsp_data[i*DATA_W +: DATA_W];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         issue_wr       <= 1'b0;
         issue_tgt      <= '0;
         issue_addr     <= '0;
         issue_data     <= '0;
         to_cnt         <= '0;
         dbg_cmd_valid  <= '0;
         host_rsp_valid <= 1'b0;
         host_rsp_data  <= '0;
         host_rsp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  issue_wr   <= head.wr;
                  issue_tgt  <= head.tgt;
                  issue_addr <= head.addr;
                  issue_data <= head.data;
                  if (head_bad) begin
                     // Nonexistent target: report straight away, no bus cycle.
                     host_rsp_valid <= 1'b1;
                     host_rsp_data  <= '0;
                     host_rsp_err   <= 1'b1;
                     state          <= S_RESP;
                  end else begin
                     dbg_cmd_valid <= N_TGT'(1) << head.tgt;
                     to_cnt        <= '0;
                     state         <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (fire) begin
                  dbg_cmd_valid <= '0;
                  state         <= issue_wr ? S_IDLE : S_CAPTURE;
               end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
                  // This was the TIMEOUT-th cycle of valid without ready.
                  dbg_cmd_valid  <= '0;
                  host_rsp_valid <= 1'b1;
                  host_rsp_data  <= '0;
                  host_rsp_err   <= 1'b1;
                  state          <= S_RESP;
               end else if (to_cnt != '1) begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_CAPTURE: begin
               host_rsp_valid <= 1'b1;
               host_rsp_data  <= rsp_sel;
               host_rsp_err   <= 1'b0;
               state          <= S_RESP;
            end
            S_RESP: begin
               if (host_rsp_ready) begin
                  host_rsp_valid <= 1'b0;
                  state          <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) tgt_reset_req <= '0;
      else       tgt_reset_req <= dbg_resetOut;
   end

endmodule

// File: tb/tb_dbg_cmd_bridge.sv
// -----------------------------------------------------------------------------
// tb_dbg_cmd_bridge
//
// Directed bench for dbg_cmd_bridge (N_TGT=3, FIFO_DEPTH=4, TIMEOUT=8).
// A scoreboard process keeps the accepted host commands in order and, every
// cycle, checks the bus and response channels against what the head command
// must produce: one-hot valid with its payload, a fire or a timeout after
// TIMEOUT valid cycles, and the expected response (target data, or err with
// zero data). Directed sequences add literal cycle-exact expectations.
// -----------------------------------------------------------------------------
module tb_dbg_cmd_bridge;

   localparam int N_TGT_TB   = 3;
   localparam int TIMEOUT_TB = 8;
   localparam logic [31:0] TV0 = 32'h1111_0000;
   localparam logic [31:0] TV1 = 32'hDEAD_BEEF;
   localparam logic [31:0] TV2 = 32'h22C0_FFEE;

   logic        clk = 1'b0;
   logic        reset;
   logic        host_cmd_valid;
   logic        host_cmd_ready;
   logic        host_cmd_wr;
   logic [1:0]  host_cmd_tgt;
   logic [7:0]  host_cmd_addr;
   logic [31:0] host_cmd_data;
   logic        host_rsp_valid;
   logic        host_rsp_ready;
   logic [31:0] host_rsp_data;
   logic        host_rsp_err;
   logic [2:0]  dbg_cmd_valid;
   logic [2:0]  dbg_cmd_ready;
   logic        dbg_cmd_payload_wr;
   logic [7:0]  dbg_cmd_payload_address;
   logic [31:0] dbg_cmd_payload_data;
   logic [95:0] dbg_rsp_data;
   logic [2:0]  dbg_resetOut;
   logic [2:0]  tgt_reset_req;

   assign dbg_rsp_data = {TV2, TV1, TV0};

   always #5 clk = ~clk;

   dbg_cmd_bridge #(
      .ADDR_W(8), .DATA_W(32), .N_TGT(N_TGT_TB), .FIFO_DEPTH(4), .TIMEOUT(TIMEOUT_TB)
   ) dut (
      .clk(clk), .reset(reset),
      .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
      .host_cmd_wr(host_cmd_wr), .host_cmd_tgt(host_cmd_tgt),
      .host_cmd_addr(host_cmd_addr), .host_cmd_data(host_cmd_data),
      .host_rsp_valid(host_rsp_valid), .host_rsp_ready(host_rsp_ready),
      .host_rsp_data(host_rsp_data), .host_rsp_err(host_rsp_err),
      .dbg_cmd_valid(dbg_cmd_valid), .dbg_cmd_ready(dbg_cmd_ready),
      .dbg_cmd_payload_wr(dbg_cmd_payload_wr),
      .dbg_cmd_payload_address(dbg_cmd_payload_address),
      .dbg_cmd_payload_data(dbg_cmd_payload_data),
      .dbg_rsp_data(dbg_rsp_data), .dbg_resetOut(dbg_resetOut),
      .tgt_reset_req(tgt_reset_req)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ scoreboard
   typedef struct packed {
      logic        wr;
      logic [1:0]  tgt;
      logic [7:0]  addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t        sb_q[$];
   int          vcyc         = 0;
   bit          awaiting_rsp = 1'b0;
   logic [31:0] exp_rdata    = '0;
   logic        exp_err      = 1'b0;
   int          fire_cnt     = 0;

   always @(negedge clk) begin : cmp_proc
      cmd_t h;
      if (reset) begin
         sb_q.delete();
         vcyc         = 0;
         awaiting_rsp = 1'b0;
      end else begin
         if (sb_q.size() == 0) begin
            check("idle_no_cmd", dbg_cmd_valid, 0);
            check("idle_no_rsp", host_rsp_valid, 0);
         end else begin
            h = sb_q[0];
            if (int'(h.tgt) >= N_TGT_TB) begin
               check("bad_no_cmd", dbg_cmd_valid, 0);
               if (host_rsp_valid) begin
                  check("bad_rsp_err", host_rsp_err, 1);
                  check("bad_rsp_data", host_rsp_data, 0);
                  if (host_rsp_ready) void'(sb_q.pop_front());
               end
            end else if (!awaiting_rsp) begin
               check("no_early_rsp", host_rsp_valid, 0);
               if (dbg_cmd_valid != 0) begin
                  check("cmd_onehot", dbg_cmd_valid, 3'b001 << h.tgt);
                  check("cmd_wr", dbg_cmd_payload_wr, h.wr);
                  check("cmd_addr", dbg_cmd_payload_address, h.addr);
                  check("cmd_data", dbg_cmd_payload_data, h.data);
                  vcyc++;
                  if (dbg_cmd_ready[h.tgt]) begin
                     fire_cnt++;
                     vcyc = 0;
                     if (h.wr) begin
                        void'(sb_q.pop_front());
                     end else begin
                        awaiting_rsp = 1'b1;
                        exp_err      = 1'b0;
                        exp_rdata    = (h.tgt == 2'd0) ? TV0 : (h.tgt == 2'd1) ? TV1 : TV2;
                     end
                  end else if (vcyc == TIMEOUT_TB) begin
                     vcyc         = 0;
                     awaiting_rsp = 1'b1;
                     exp_err      = 1'b1;
                     exp_rdata    = '0;
                  end
               end
            end else begin
               check("no_cmd_during_rsp", dbg_cmd_valid, 0);
               if (host_rsp_valid) begin
                  check("rsp_err", host_rsp_err, exp_err);
                  check("rsp_data", host_rsp_data, exp_rdata);
                  if (host_rsp_ready) begin
                     void'(sb_q.pop_front());
                     awaiting_rsp = 1'b0;
                  end
               end
            end
         end
         if (host_cmd_valid && host_cmd_ready)
            sb_q.push_back('{wr: host_cmd_wr, tgt: host_cmd_tgt,
                             addr: host_cmd_addr, data: host_cmd_data});
      end
   end

   // ------------------------------------------------------------ helpers
   task automatic drive_cmd(input logic wr, input logic [1:0] tgt,
                            input logic [7:0] addr, input logic [31:0] data);
      host_cmd_valid = 1'b1;
      host_cmd_wr    = wr;
      host_cmd_tgt   = tgt;
      host_cmd_addr  = addr;
      host_cmd_data  = data;
   endtask

   task automatic clr_cmd();
      host_cmd_valid = 1'b0;
   endtask

   // Starts on the next edge, holds valid until accepted (bounded), returns
   // just after the accepting edge.
   task automatic push(input logic wr, input logic [1:0] tgt,
                       input logic [7:0] addr, input logic [31:0] data);
      logic ok = 1'b0;
      @(posedge clk); #1;
      drive_cmd(wr, tgt, addr, data);
      for (int n = 0; n < 100 && !ok; n++) begin
         @(negedge clk);
         ok = host_cmd_ready;
         @(posedge clk); #1;
      end
      clr_cmd();
      check("push_accept", ok, 1);
   endtask

   task automatic wait_rsp();
      for (int n = 0; n < 50 && !host_rsp_valid; n++) @(negedge clk);
      check("wait_rsp", host_rsp_valid, 1);
   endtask

   // Waits until every accepted command has completed; ends on a negedge.
   task automatic wait_idle();
      @(negedge clk);
      for (int n = 0; n < 300 && (sb_q.size() != 0 || dbg_cmd_valid != 0 || host_rsp_valid); n++)
         @(negedge clk);
      check("drain", sb_q.size(), 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   // ------------------------------------------------------------ stimulus
   int          vcnt, rsp_cyc, f0;
   logic        r_err;
   logic [31:0] r_data;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b1;
      host_cmd_valid = 1'b0;
      host_cmd_wr    = 1'b0;
      host_cmd_tgt   = '0;
      host_cmd_addr  = '0;
      host_cmd_data  = '0;
      host_rsp_ready = 1'b1;
      dbg_cmd_ready  = 3'b111;
      dbg_resetOut   = 3'b000;

      // Reset values
      repeat (2) @(negedge clk);
      check("rst_cmd_valid", dbg_cmd_valid, 0);
      check("rst_cmd_ready", host_cmd_ready, 1);
      check("rst_rsp_valid", host_rsp_valid, 0);
      check("rst_rsp_data", host_rsp_data, 0);
      check("rst_rsp_err", host_rsp_err, 0);
      check("rst_payload", {dbg_cmd_payload_wr, dbg_cmd_payload_address, dbg_cmd_payload_data}, 0);
      check("rst_tgt_reset_req", tgt_reset_req, 0);
      @(posedge clk); #1 reset = 1'b0;

      // Read latency, tgt=1, ready=1
      @(posedge clk); #1;
      drive_cmd(1'b0, 2'd1, 8'h04, 32'h0);                      // cycle 0
      @(negedge clk); check("A_push_ready", host_cmd_ready, 1);
      @(posedge clk); #1; clr_cmd();                             // cycle 1
      @(negedge clk); check("A_valid_c1", dbg_cmd_valid, 0);
      next_cycle();                                              // cycle 2
      check("A_valid_c2", dbg_cmd_valid, 3'b010);
      check("A_addr_c2", dbg_cmd_payload_address, 8'h04);
      check("A_wr_c2", dbg_cmd_payload_wr, 0);
      next_cycle();                                              // cycle 3
      check("A_valid_c3", dbg_cmd_valid, 0);
      check("A_rspv_c3", host_rsp_valid, 0);
      next_cycle();                                              // cycle 4
      check("A_rspv_c4", host_rsp_valid, 1);
      check("A_rspd_c4", host_rsp_data, 32'hDEAD_BEEF);
      check("A_rspe_c4", host_rsp_err, 0);
      wait_idle();

      // Write then read back-to-back: write fires at 2, read issues at 4
      @(posedge clk); #1;
      drive_cmd(1'b1, 2'd0, 8'h08, 32'hA5A5_0001);               // cycle 0
      @(posedge clk); #1;
      drive_cmd(1'b0, 2'd2, 8'h0C, 32'h0);                       // cycle 1
      @(posedge clk); #1; clr_cmd();                             // cycle 2
      @(negedge clk);
      check("W_valid_c2", dbg_cmd_valid, 3'b001);
      check("W_wr_c2", dbg_cmd_payload_wr, 1);
      check("W_data_c2", dbg_cmd_payload_data, 32'hA5A5_0001);
      next_cycle();                                              // cycle 3
      check("W_valid_c3", dbg_cmd_valid, 0);
      next_cycle();                                              // cycle 4
      check("W_valid_c4", dbg_cmd_valid, 3'b100);
      check("W_addr_c4", dbg_cmd_payload_address, 8'h0C);
      wait_idle();

      // Back-pressure: a stalled response keeps the FSM busy while the FIFO fills
      host_rsp_ready = 1'b0;
      push(1'b0, 2'd0, 8'h10, 32'h0);
      wait_rsp();
      push(1'b1, 2'd0, 8'h30, 32'h1000_0001);
      push(1'b1, 2'd1, 8'h31, 32'h1000_0002);
      push(1'b1, 2'd2, 8'h32, 32'h1000_0003);
      push(1'b1, 2'd1, 8'h33, 32'h1000_0004);
      check("B_full", host_cmd_ready, 0);
      f0 = fire_cnt;
      drive_cmd(1'b1, 2'd0, 8'h34, 32'h1000_0005);
      dbg_cmd_ready  = 3'b000;
      host_rsp_ready = 1'b1;
      @(negedge clk); check("B_full_hold", host_cmd_ready, 0);    // response leaves
      @(posedge clk); #1;
      @(negedge clk); check("B_ready_pop", host_cmd_ready, 0);    // pop cycle
      @(posedge clk); #1;
      @(negedge clk); check("B_ready_after", host_cmd_ready, 1);  // 5th accepted here
      @(posedge clk); #1; clr_cmd();
      repeat (3) @(posedge clk);
      #1 dbg_cmd_ready = 3'b111;
      wait_idle();
      check("B_fires", fire_cnt - f0, 5);

      // Timeout: read tgt0 with ready held low
      dbg_cmd_ready = 3'b000;
      @(posedge clk); #1;
      drive_cmd(1'b0, 2'd0, 8'h40, 32'h0);                       // cycle 0
      @(posedge clk); #1; clr_cmd();                             // cycle 1
      vcnt = 0; rsp_cyc = -1; r_err = 1'b0; r_data = 32'hFFFF_FFFF;
      for (int c = 1; c <= 14; c++) begin
         @(negedge clk);
         if (dbg_cmd_valid != 0) vcnt++;
         if (host_rsp_valid && rsp_cyc < 0) begin
            rsp_cyc = c;
            r_err   = host_rsp_err;
            r_data  = host_rsp_data;
         end
         @(posedge clk); #1;
      end
      check("C_valid_cycles", vcnt, 8);
      check("C_rsp_cycle", rsp_cyc, 10);
      check("C_rsp_err", r_err, 1);
      check("C_rsp_data", r_data, 0);
      dbg_cmd_ready = 3'b111;
      push(1'b0, 2'd0, 8'h44, 32'h0);
      wait_idle();

      // Bad target 3, then a queued read of tgt 2
      @(posedge clk); #1;
      drive_cmd(1'b0, 2'd3, 8'h50, 32'h0);                       // cycle 0
      @(posedge clk); #1;
      drive_cmd(1'b0, 2'd2, 8'h54, 32'h0);                       // cycle 1
      @(negedge clk); check("D_valid_c1", dbg_cmd_valid, 0);
      @(posedge clk); #1; clr_cmd();                             // cycle 2
      @(negedge clk);
      check("D_rspv_c2", host_rsp_valid, 1);
      check("D_rspe_c2", host_rsp_err, 1);
      check("D_rspd_c2", host_rsp_data, 0);
      check("D_valid_c2", dbg_cmd_valid, 0);
      next_cycle();                                              // cycle 3
      check("D_valid_c3", dbg_cmd_valid, 0);
      next_cycle();                                              // cycle 4
      check("D_valid_c4", dbg_cmd_valid, 3'b100);
      next_cycle();                                              // cycle 5
      next_cycle();                                              // cycle 6
      check("D_rspv_c6", host_rsp_valid, 1);
      check("D_rspd_c6", host_rsp_data, 32'h22C0_FFEE);
      check("D_rspe_c6", host_rsp_err, 0);
      wait_idle();

      // Target reset request is a one-cycle registered copy
      @(posedge clk); #1 dbg_resetOut = 3'b101;
      @(negedge clk); check("R_before", tgt_reset_req, 3'b000);
      next_cycle();   check("R_after", tgt_reset_req, 3'b101);
      @(posedge clk); #1 dbg_resetOut = 3'b000;
      @(negedge clk); check("R_hold", tgt_reset_req, 3'b101);
      next_cycle();   check("R_clear", tgt_reset_req, 3'b000);

      // Response stall with two queued reads, then reset mid-stall
      host_rsp_ready = 1'b0;
      push(1'b0, 2'd1, 8'h20, 32'h0);
      push(1'b0, 2'd2, 8'h24, 32'h0);
      wait_rsp();
      for (int i = 0; i < 6; i++) begin
         next_cycle();
         check("E_hold_valid", host_rsp_valid, 1);
         check("E_hold_data", host_rsp_data, 32'hDEAD_BEEF);
         check("E_no_issue", dbg_cmd_valid, 0);
      end
      @(posedge clk); #2 reset = 1'b1;
      #1;
      check("E_rst_rspv", host_rsp_valid, 0);
      check("E_rst_rspd", host_rsp_data, 0);
      check("E_rst_cmdv", dbg_cmd_valid, 0);
      check("E_rst_ready", host_cmd_ready, 1);
      check("E_rst_payload", {dbg_cmd_payload_wr, dbg_cmd_payload_address}, 0);
      @(negedge clk);
      @(posedge clk); #1 reset = 1'b0;
      host_rsp_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         check("E_no_stale_rsp", host_rsp_valid, 0);
         check("E_no_stale_cmd", dbg_cmd_valid, 0);
      end
      push(1'b0, 2'd1, 8'h28, 32'h0);
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
